// File: rtl/pry2oht_pkg.sv
// Shared constants and elaboration-time helpers for the priority-to-one-hot tree.
package pry2oht_pkg;

    localparam int IMP_CHAIN = 0;
    localparam int IMP_MASK  = 1;
    localparam int IMP_ARITH = 2;

    // True when split is a power of two in [2, width] and width == split**k, k >= 1.
    function automatic bit pry2oht_legal(input int width, input int split);
        int w;
        if (split < 2 || split > width || (split & (split - 1)) != 0) begin
            return 1'b0;
        end
        w = width;
        while (w > 1 && (w % split) == 0) begin
            w = w / split;
        end
        return (w == 1);
    endfunction

endpackage

// File: rtl/pry2oht_base.sv
// Combinational WIDTH-bit priority node: keeps the lowest set bit, flags any set bit.
module pry2oht_base
    import pry2oht_pkg::*;
#(
    parameter int WIDTH          = 2,
    parameter int IMPLEMENTATION = IMP_CHAIN
) (
    input  logic [WIDTH-1:0] pry,
    output logic [WIDTH-1:0] oht,
    output logic             vld
);

    generate
        if (IMPLEMENTATION == IMP_CHAIN) begin : g_chain
            logic seen;

            // NOTE: blocking assignments are correct here; the running OR must
            // update within one evaluation so each bit sees all lower bits.
            always_comb begin
                oht  = '0;
                seen = 1'b0;
                for (int i = 0; i < WIDTH; i++) begin
                    oht[i] = pry[i] & ~seen;
                    seen   = seen | pry[i];
                end
                vld = seen;
            end
        end else if (IMPLEMENTATION == IMP_MASK) begin : g_mask
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                if (i == 0) begin : g_lsb
                    assign oht[i] = pry[i];
                end else begin : g_upper
                    assign oht[i] = pry[i] & ~(|pry[i-1:0]);
                end
            end
            assign vld = |pry;
        end else begin : g_arith
            // Two's complement isolates the lowest set bit; X above it will smear.
            assign oht = pry & (~pry + WIDTH'(1));
            assign vld = |pry;
        end
    endgenerate

endmodule

// File: rtl/pry2oht_tree_comb.sv
// Recursive SPLIT-ary tree of priority nodes; purely combinational.
module pry2oht_tree_comb
    import pry2oht_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int SPLIT          = 2,
    parameter int IMPLEMENTATION = IMP_CHAIN
) (
    input  logic [WIDTH-1:0] pry,
    output logic [WIDTH-1:0] oht,
    output logic             vld
);

    generate
        if (WIDTH <= SPLIT) begin : g_leaf
            pry2oht_base #(
                .WIDTH          (WIDTH),
                .IMPLEMENTATION (IMPLEMENTATION)
            ) u_leaf (
                .pry (pry),
                .oht (oht),
                .vld (vld)
            );
        end else begin : g_node
            localparam int SUB = WIDTH / SPLIT;

            logic [SPLIT-1:0] child_vld;
            logic [SPLIT-1:0] sel;
            logic [WIDTH-1:0] child_oht;

            for (genvar c = 0; c < SPLIT; c++) begin : g_child
                pry2oht_tree_comb #(
                    .WIDTH          (SUB),
                    .SPLIT          (SPLIT),
                    .IMPLEMENTATION (IMPLEMENTATION)
                ) u_child (
                    .pry (pry[c*SUB +: SUB]),
                    .oht (child_oht[c*SUB +: SUB]),
                    .vld (child_vld[c])
                );

                // Only the lowest non-empty child may pass its one-hot upward.
                assign oht[c*SUB +: SUB] = child_oht[c*SUB +: SUB] & {SUB{sel[c]}};
            end

            pry2oht_base #(
                .WIDTH          (SPLIT),
                .IMPLEMENTATION (IMPLEMENTATION)
            ) u_sel (
                .pry (child_vld),
                .oht (sel),
                .vld (vld)
            );
        end
    endgenerate

endmodule

// File: rtl/pry2oht_tree_reg.sv
// Registered priority-to-one-hot converter: lowest set bit of pry, one cycle latency.
module pry2oht_tree_reg
    import pry2oht_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int SPLIT          = 2,
    parameter int IMPLEMENTATION = IMP_CHAIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pry,
    output logic [WIDTH-1:0] oht,
    output logic             vld
);

    logic [WIDTH-1:0] oht_c;
    logic             vld_c;

    generate
        if (!pry2oht_legal(WIDTH, SPLIT)) begin : g_bad_geometry
            $error("pry2oht_tree_reg: WIDTH=%0d is not a power of SPLIT=%0d", WIDTH, SPLIT);
        end
        if (IMPLEMENTATION < IMP_CHAIN || IMPLEMENTATION > IMP_ARITH) begin : g_bad_impl
            $error("pry2oht_tree_reg: IMPLEMENTATION=%0d unsupported", IMPLEMENTATION);
        end
    endgenerate

    pry2oht_tree_comb #(
        .WIDTH          (WIDTH),
        .SPLIT          (SPLIT),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_tree (
        .pry (pry),
        .oht (oht_c),
        .vld (vld_c)
    );

    // NOTE: output flops get the async reset; there is no storage array here,
    // so every state bit is cleared and mid-stream reset drops the in-flight value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oht <= '0;
            vld <= 1'b0;
        end else begin
            oht <= oht_c;
            vld <= vld_c;
        end
    end

endmodule

// File: tb/tb_pry2oht_tree_reg.sv
// Scoreboard bench: directed vectors push expectations, a monitor pops and compares.
module tb_pry2oht_tree_reg;

    logic        clk;
    logic        rst;
    logic [31:0] pry32;
    logic [7:0]  pry8;

    logic [31:0] oht32 [3];
    logic        vld32 [3];
    logic [7:0]  oht8  [6];
    logic        vld8  [6];

    // 32-bit, SPLIT=2, one instance per implementation.
    for (genvar g = 0; g < 3; g++) begin : g32
        pry2oht_tree_reg #(
            .WIDTH          (32),
            .SPLIT          (2),
            .IMPLEMENTATION (g)
        ) dut (
            .clk (clk),
            .rst (rst),
            .pry (pry32),
            .oht (oht32[g]),
            .vld (vld32[g])
        );
    end

    // 8-bit: index = imp*2 + (SPLIT==4).
    for (genvar g = 0; g < 6; g++) begin : g8
        pry2oht_tree_reg #(
            .WIDTH          (8),
            .SPLIT          ((g % 2 == 1) ? 4 : 2),
            .IMPLEMENTATION (g / 2)
        ) dut (
            .clk (clk),
            .rst (rst),
            .pry (pry8),
            .oht (oht8[g]),
            .vld (vld8[g])
        );
    end

    typedef struct {
        logic [31:0] oht32;
        logic        vld32;
        bit          chk_arith;
        logic [7:0]  oht8;
        logic        vld8;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref8(input logic [7:0] p);
        logic [7:0] r;
        bit         found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found && p[i]) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic step(input logic [31:0] p32, input logic [31:0] e32, input logic ev32,
                        input bit arith, input logic [7:0] p8);
        exp_t e;
        @(negedge clk);
        pry32       = p32;
        pry8        = p8;
        e.oht32     = e32;
        e.vld32     = ev32;
        e.chk_arith = arith;
        e.oht8      = ref8(p8);
        e.vld8      = |p8;
        sb.push_back(e);
    endtask

    task automatic chk_zero(input string tag);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s oht32[imp%0d]", tag, g), oht32[g], 32'h0);
            check($sformatf("%s vld32[imp%0d]", tag, g), {31'b0, vld32[g]}, 32'h0);
        end
        for (int g = 0; g < 6; g++) begin
            check($sformatf("%s oht8[%0d]", tag, g), {24'b0, oht8[g]}, 32'h0);
            check($sformatf("%s vld8[%0d]", tag, g), {31'b0, vld8[g]}, 32'h0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #2;
        check("scoreboard drained", sb.size(), 0);
    endtask

    // Monitor: the DUT presents a new result every cycle, sampled 1 after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            for (int g = 0; g < 3; g++) begin
                if (g != 2 || e.chk_arith) begin
                    check($sformatf("oht32[imp%0d]", g), oht32[g], e.oht32);
                    check($sformatf("vld32[imp%0d]", g), {31'b0, vld32[g]}, {31'b0, e.vld32});
                end
            end
            for (int g = 0; g < 6; g++) begin
                check($sformatf("oht8[%0d]", g), {24'b0, oht8[g]}, {24'b0, e.oht8});
                check($sformatf("vld8[%0d]", g), {31'b0, vld8[g]}, {31'b0, e.vld8});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] p;

        // Reset holds outputs low whatever pry is.
        rst   = 1'b1;
        pry32 = 32'hdead_beef;
        pry8  = 8'ha5;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("in reset");
        @(negedge clk);
        pry32 = '1;
        pry8  = '1;
        @(posedge clk);
        #1;
        chk_zero("in reset all-ones");

        // Release with idle input.
        step(32'h0, 32'h0, 1'b0, 1'b1, 8'h00);
        rst = 1'b0;

        // One-hot walk.
        for (int i = 0; i < 32; i++) begin
            step(32'h1 << i, 32'h1 << i, 1'b1, 1'b1, 8'h1 << (i % 8));
        end

        // Lowest set bit known, lower bits zero, upper bits X (arith unchecked).
        for (int i = 0; i < 32; i++) begin
            p = '0;
            p[i] = 1'b1;
            for (int j = i + 1; j < 32; j++) p[j] = 1'bx;
            step(p, 32'h1 << i, 1'b1, 1'b0, 8'h00);
        end

        // All ones keeps only bit 0; the 8-bit example from the plan.
        step(32'hffff_ffff, 32'h0000_0001, 1'b1, 1'b1, 8'hff);
        step(32'h0101_0100, 32'h0000_0100, 1'b1, 1'b1, 8'b1011_0100);

        // Exhaustive 8-bit against the lowest-set-bit reference.
        for (int v = 0; v < 256; v++) begin
            step(32'h0, 32'h0, 1'b0, 1'b1, 8'(v));
        end

        // Back-to-back pipelining.
        step(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 8'h80);
        step(32'h0000_0006, 32'h0000_0002, 1'b1, 1'b1, 8'h06);
        step(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 8'h00);
        drain();

        // Asynchronous reset between edges while pry=F.
        step(32'h0000_000f, 32'h0000_0001, 1'b1, 1'b1, 8'h0f);
        drain();
        #1;
        rst = 1'b1;
        #1;
        chk_zero("async reset");
        @(negedge clk);
        chk_zero("reset held");
        step(32'h0000_000f, 32'h0000_0001, 1'b1, 1'b1, 8'h0f);
        rst = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
